bignum_operand_streamer: RTL and testbench

- Transmit side of the operand stream consumed by the streaming big-number multiplier.
- Holds two BITS_IN_NUM-bit operands n and m in a dual-port BRAM, loaded by address from the host/control side.
- On start, waits for the consumer's ready, then emits both operands least-significant block first.
- Emission is one contiguous burst of BLOCKS beats, REGISTER_SIZE bits per beat, with valid on every beat and a last flag on the final beat.

---
 rtl/bignum_stream_pkg.sv | 23 ++
 rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv | 59 +++++
 rtl/bignum_operand_streamer.sv | 136 +++++++++++++
 tb/tb_bignum_operand_streamer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bignum_stream_pkg.sv
// rtl/bignum_stream_pkg.sv - shared defaults, derived sizes and state type for the operand streamer
package bignum_stream_pkg;

   localparam int DEFAULT_REGISTER_SIZE = 32;
   localparam int DEFAULT_BITS_IN_NUM   = 4096;

   // Zero-width addresses are illegal, so a single-entry space still gets one bit.
   function automatic int addr_bits(input int entries);
      return (entries > 1) ? $clog2(entries) : 1;
   endfunction

   localparam int DEFAULT_BLOCKS     = DEFAULT_BITS_IN_NUM / DEFAULT_REGISTER_SIZE;
   localparam int DEFAULT_ADDR_WIDTH = addr_bits(DEFAULT_BLOCKS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_READY,
      ST_READING,
      ST_DRAIN,
      ST_DONE
   } stream_state_t;

endpackage

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv - true dual-port read-first BRAM, 2-cycle read with output register
module xilinx_true_dual_port_read_first_2_clock_ram #(
   parameter int RAM_WIDTH = 18,
   parameter int RAM_DEPTH = 1024,
   localparam int ADDR_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic [ADDR_W-1:0]    addra,
   input  logic [ADDR_W-1:0]    addrb,
   input  logic [RAM_WIDTH-1:0] dina,
   input  logic [RAM_WIDTH-1:0] dinb,
   input  logic                 clka,
   input  logic                 clkb,
   input  logic                 wea,
   input  logic                 web,
   input  logic                 ena,
   input  logic                 enb,
   input  logic                 rsta,
   input  logic                 rstb,
   input  logic                 regcea,
   input  logic                 regceb,
   output logic [RAM_WIDTH-1:0] douta,
   output logic [RAM_WIDTH-1:0] doutb
);

   logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
   logic [RAM_WIDTH-1:0] ram_a;
   logic [RAM_WIDTH-1:0] ram_b;

   // Both write ports commit in the clka domain so the array has a single writer.
   always_ff @(posedge clka) begin
      if (ena) begin
         if (wea)
            mem[addra] <= dina;
         ram_a <= mem[addra];
      end
      if (enb && web)
         mem[addrb] <= dinb;
   end

   always_ff @(posedge clkb) begin
      if (enb)
         ram_b <= mem[addrb];
   end

   always_ff @(posedge clka) begin
      if (rsta)
         douta <= '0;
      else if (regcea)
         douta <= ram_a;
   end

   always_ff @(posedge clkb) begin
      if (rstb)
         doutb <= '0;
      else if (regceb)
         doutb <= ram_b;
   end

endmodule

// File: rtl/bignum_operand_streamer.sv
// rtl/bignum_operand_streamer.sv - streams stored n/m operands LSB block first as one contiguous burst
module bignum_operand_streamer
   import bignum_stream_pkg::*;
#(
   parameter int REGISTER_SIZE = DEFAULT_REGISTER_SIZE,
   parameter int BITS_IN_NUM   = DEFAULT_BITS_IN_NUM,
   localparam int BLOCKS       = BITS_IN_NUM / REGISTER_SIZE,
   localparam int ADDR_WIDTH   = addr_bits(BLOCKS)
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     load_we_in,
   input  logic [ADDR_WIDTH-1:0]    load_addr_in,
   input  logic [REGISTER_SIZE-1:0] load_n_in,
   input  logic [REGISTER_SIZE-1:0] load_m_in,
   input  logic                     start_in,
   input  logic                     consumer_ready_in,
   output logic [REGISTER_SIZE-1:0] n_out,
   output logic [REGISTER_SIZE-1:0] m_out,
   output logic                     valid_out,
   output logic                     last_out,
   output logic                     busy_out,
   output logic                     done_out
);

   localparam int RAM_ADDR_W = addr_bits(2 * BLOCKS);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(BLOCKS - 1);
   localparam logic [RAM_ADDR_W-1:0] M_BASE    = RAM_ADDR_W'(BLOCKS);

   stream_state_t state, state_next;
   logic [ADDR_WIDTH-1:0]    rd_cnt;
   logic [1:0]               rv_pipe;
   logic [1:0]               last_pipe;
   logic                     reading;
   logic                     ram_we;
   logic [RAM_ADDR_W-1:0]    addr_a;
   logic [RAM_ADDR_W-1:0]    addr_b;
   logic [REGISTER_SIZE-1:0] ram_n;
   logic [REGISTER_SIZE-1:0] ram_m;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy_out   = (state != ST_IDLE);
      done_out   = 1'b0;
      reading    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_in)
               state_next = consumer_ready_in ? ST_READING : ST_WAIT_READY;
         end
         ST_WAIT_READY: begin
            if (consumer_ready_in)
               state_next = ST_READING;
         end
         ST_READING: begin
            reading = 1'b1;
            if (rd_cnt == LAST_ADDR)
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (rv_pipe == 2'b00)
               state_next = ST_DONE;
         end
         ST_DONE: begin
            done_out   = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Loads own the RAM ports only in IDLE; m shares the address with an offset of BLOCKS.
   always_comb begin
      ram_we = (state == ST_IDLE) && load_we_in;
      addr_a = reading ? RAM_ADDR_W'(rd_cnt) : RAM_ADDR_W'(load_addr_in);
      addr_b = M_BASE + addr_a;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         rd_cnt    <= '0;
         rv_pipe   <= '0;
         last_pipe <= '0;
      end else begin
         if (reading)
            rd_cnt <= (rd_cnt == LAST_ADDR) ? '0 : rd_cnt + 1'b1;
         rv_pipe   <= {rv_pipe[0], reading};
         last_pipe <= {last_pipe[0], reading && (rd_cnt == LAST_ADDR)};
      end
   end

   // rv_pipe[1] lines up with the RAM output register, so this stage makes the third cycle.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         n_out     <= '0;
         m_out     <= '0;
         valid_out <= 1'b0;
         last_out  <= 1'b0;
      end else begin
         n_out     <= rv_pipe[1] ? ram_n : '0;
         m_out     <= rv_pipe[1] ? ram_m : '0;
         valid_out <= rv_pipe[1];
         last_out  <= last_pipe[1];
      end
   end

   xilinx_true_dual_port_read_first_2_clock_ram #(
      .RAM_WIDTH (REGISTER_SIZE),
      .RAM_DEPTH (2 * BLOCKS)
   ) u_operand_ram (
      .addra  (addr_a),
      .addrb  (addr_b),
      .dina   (load_n_in),
      .dinb   (load_m_in),
      .clka   (clk_in),
      .clkb   (clk_in),
      .wea    (ram_we),
      .web    (ram_we),
      .ena    (1'b1),
      .enb    (1'b1),
      .rsta   (1'b0),
      .rstb   (1'b0),
      .regcea (1'b1),
      .regceb (1'b1),
      .douta  (ram_n),
      .doutb  (ram_m)
   );

endmodule

// File: tb/tb_bignum_operand_streamer.sv
// tb/tb_bignum_operand_streamer.sv - directed self-checking bench for bignum_operand_streamer
module tb_bignum_operand_streamer;

   localparam int RS  = 32;
   localparam int BN  = 128;
   localparam int NB  = BN / RS;
   localparam int AW  = 2;

   logic          clk_in;
   logic          rst_in;
   logic          load_we_in;
   logic [AW-1:0] load_addr_in;
   logic [RS-1:0] load_n_in;
   logic [RS-1:0] load_m_in;
   logic          start_in;
   logic          consumer_ready_in;
   logic [RS-1:0] n_out;
   logic [RS-1:0] m_out;
   logic          valid_out;
   logic          last_out;
   logic          busy_out;
   logic          done_out;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;

   logic [BN-1:0]     acc_n;
   logic [BN-1:0]     acc_m;
   logic [2*BN-1:0]   prod;
   logic [NB-1:0][RS-1:0] exp_n;
   logic [NB-1:0][RS-1:0] exp_m;
   int                d0;

   bignum_operand_streamer #(
      .REGISTER_SIZE (RS),
      .BITS_IN_NUM   (BN)
   ) dut (
      .clk_in            (clk_in),
      .rst_in            (rst_in),
      .load_we_in        (load_we_in),
      .load_addr_in      (load_addr_in),
      .load_n_in         (load_n_in),
      .load_m_in         (load_m_in),
      .start_in          (start_in),
      .consumer_ready_in (consumer_ready_in),
      .n_out             (n_out),
      .m_out             (m_out),
      .valid_out         (valid_out),
      .last_out          (last_out),
      .busy_out          (busy_out),
      .done_out          (done_out)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   always @(negedge clk_in) begin
      if (done_out)
         done_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, expv, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [RS-1:0] n, input logic [RS-1:0] m);
      load_we_in   = 1'b1;
      load_addr_in = a;
      load_n_in    = n;
      load_m_in    = m;
      tick;
      load_we_in   = 1'b0;
   endtask

   task automatic pulse_start;
      start_in = 1'b1;
      tick;
      start_in = 1'b0;
   endtask

   // Entered one cycle after the accepting edge; pre idle cycles, then NB beats, DONE, IDLE.
   task automatic run_burst(input int pre, input bit meddle);
      for (int i = 0; i < pre; i++) begin
         if (meddle && i == 0) begin
            load_we_in   = 1'b1;
            load_addr_in = '0;
            load_n_in    = 32'hFF;
            start_in     = 1'b1;
         end
         tick;
         load_we_in = 1'b0;
         start_in   = 1'b0;
         check("pre_valid", valid_out, 0);
         check("pre_busy", busy_out, 1);
      end
      for (int k = 0; k < NB; k++) begin
         tick;
         check("beat_valid", valid_out, 1);
         check("beat_n", n_out, exp_n[k]);
         check("beat_m", m_out, exp_m[k]);
         check("beat_last", last_out, (k == NB - 1) ? 1 : 0);
         acc_n[k*RS +: RS] = n_out;
         acc_m[k*RS +: RS] = m_out;
      end
      tick;
      check("done_pulse", done_out, 1);
      check("done_valid", valid_out, 0);
      check("done_n_zero", n_out, 0);
      check("done_busy", busy_out, 1);
      tick;
      check("idle_done", done_out, 0);
      check("idle_busy", busy_out, 0);
   endtask

   initial begin
      rst_in = 1'b1;
      load_we_in = 1'b0;
      load_addr_in = '0;
      load_n_in = '0;
      load_m_in = '0;
      start_in = 1'b0;
      consumer_ready_in = 1'b0;
      acc_n = '0;
      acc_m = '0;
      tick;
      tick;
      check("rst_valid", valid_out, 0);
      check("rst_last", last_out, 0);
      check("rst_n", n_out, 0);
      check("rst_m", m_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_done", done_out, 0);
      rst_in = 1'b0;
      tick;

      // 1: basic burst
      for (int k = 0; k < NB; k++) begin
         exp_n[k] = RS'(32'h11 * (k + 1));
         exp_m[k] = RS'(32'hA1 + k);
         load(AW'(k), exp_n[k], exp_m[k]);
      end
      consumer_ready_in = 1'b1;
      pulse_start;
      run_burst(2, 1'b0);

      // 2: wait for consumer ready
      consumer_ready_in = 1'b0;
      pulse_start;
      for (int i = 0; i < 10; i++) begin
         tick;
         check("wait_valid", valid_out, 0);
         check("wait_busy", busy_out, 1);
      end
      consumer_ready_in = 1'b1;
      tick;
      run_burst(2, 1'b0);

      // 3: load and start ignored during a burst
      d0 = done_cnt;
      pulse_start;
      run_burst(2, 1'b1);
      pulse_start;
      run_burst(2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick;
         check("post_idle_valid", valid_out, 0);
      end
      check("burst_count", 64'(done_cnt - d0), 2);

      // 4: reset mid-burst
      pulse_start;
      for (int i = 0; i < 5; i++)
         tick;
      check("mid_beat2_valid", valid_out, 1);
      check("mid_beat2_n", n_out, 32'h33);
      rst_in = 1'b1;
      #1;
      check("arst_valid", valid_out, 0);
      check("arst_n", n_out, 0);
      check("arst_m", m_out, 0);
      check("arst_busy", busy_out, 0);
      #1;
      rst_in = 1'b0;
      tick;
      tick;
      check("post_rst_busy", busy_out, 0);
      check("post_rst_valid", valid_out, 0);
      pulse_start;
      run_burst(2, 1'b0);

      // 5: load and start in the same IDLE cycle
      exp_n[3] = 32'h99;
      load_we_in   = 1'b1;
      load_addr_in = AW'(3);
      load_n_in    = 32'h99;
      load_m_in    = 32'hA4;
      start_in     = 1'b1;
      tick;
      load_we_in = 1'b0;
      start_in   = 1'b0;
      run_burst(2, 1'b0);

      // 6: n=3, m=5 as a 128-bit pair; product block 0 must be 15
      for (int k = 0; k < NB; k++) begin
         exp_n[k] = (k == 0) ? 32'd3 : 32'd0;
         exp_m[k] = (k == 0) ? 32'd5 : 32'd0;
         load(AW'(k), exp_n[k], exp_m[k]);
      end
      pulse_start;
      run_burst(2, 1'b0);
      prod = {{BN{1'b0}}, acc_n} * {{BN{1'b0}}, acc_m};
      check("prod_blk0", prod[RS-1:0], 15);
      check("prod_upper_zero", (prod[2*BN-1:RS] != '0) ? 1 : 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
